// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: conditions the raw lines, deframes 11-bit frames and
// strips E0/F0 prefixes to report one scan code per key event.
module ps2_scancode_rx #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic       key_release,
    output logic       key_extended,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic          filt_q, filt_d;
    logic [3:0]    filt_cnt_q, filt_cnt_d;
    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tout_q, tout_d;
    logic          byte_rdy_q, byte_rdy_d;
    logic          err_q, err_d;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic [7:0]    keycode_q, keycode_d;
    logic          key_valid_q, key_valid_d;
    logic          key_release_q, key_release_d;
    logic          key_extended_q, key_extended_d;
    logic          frame_err_q, frame_err_d;

    logic clk_s, dat_s, fall_stb;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    // Input conditioning: the filtered level only follows a run of FILTER_LEN disagreeing samples.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        filt_d     = filt_q;
        filt_cnt_d = 4'd0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == 4'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + 4'd1;
            end
        end
    end

    assign fall_stb = filt_q & ~filt_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        byte_rdy_d = 1'b0;
        err_d      = 1'b0;
        tout_d     = (state_q == StIdle || fall_stb) ? '0 : tout_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (fall_stb && !dat_s) begin
                    state_d   = StData;
                    bit_cnt_d = 3'd0;
                end
            end
            StData: begin
                if (fall_stb) begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
            end
            StParity: begin
                if (fall_stb) begin
                    par_d   = dat_s;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (fall_stb) begin
                    if (dat_s && (^{shift_q, par_q})) byte_rdy_d = 1'b1;
                    else                              err_d      = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && !fall_stb && tout_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = StIdle;
            err_d   = 1'b1;
            tout_d  = '0;
        end
    end

    // Prefix decoder runs one cycle after the frame completes; shift_q is stable then.
    always_comb begin
        ext_d          = ext_q;
        brk_d          = brk_q;
        keycode_d      = keycode_q;
        key_valid_d    = 1'b0;
        key_release_d  = key_release_q;
        key_extended_d = key_extended_q;
        frame_err_d    = err_q;
        if (err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_rdy_q) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                keycode_d      = shift_q;
                key_release_d  = brk_q;
                key_extended_d = ext_q;
                key_valid_d    = 1'b1;
                ext_d          = 1'b0;
                brk_d          = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync_q     <= 2'b11;
            dat_sync_q     <= 2'b11;
            filt_q         <= 1'b1;
            filt_cnt_q     <= 4'd0;
            state_q        <= StIdle;
            bit_cnt_q      <= 3'd0;
            shift_q        <= 8'd0;
            par_q          <= 1'b0;
            tout_q         <= '0;
            byte_rdy_q     <= 1'b0;
            err_q          <= 1'b0;
            ext_q          <= 1'b0;
            brk_q          <= 1'b0;
            keycode_q      <= 8'd0;
            key_valid_q    <= 1'b0;
            key_release_q  <= 1'b0;
            key_extended_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            clk_sync_q     <= clk_sync_d;
            dat_sync_q     <= dat_sync_d;
            filt_q         <= filt_d;
            filt_cnt_q     <= filt_cnt_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            par_q          <= par_d;
            tout_q         <= tout_d;
            byte_rdy_q     <= byte_rdy_d;
            err_q          <= err_d;
            ext_q          <= ext_d;
            brk_q          <= brk_d;
            keycode_q      <= keycode_d;
            key_valid_q    <= key_valid_d;
            key_release_q  <= key_release_d;
            key_extended_q <= key_extended_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign keycode      = keycode_q;
    assign key_valid    = key_valid_q;
    assign key_release  = key_release_q;
    assign key_extended = key_extended_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: directed PS/2 frames, expected events
// queued by the stimulus and consumed by an independent output monitor.
module tb_ps2_scancode_rx;

    localparam int HALF = 200;

    typedef struct packed {
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       key_valid, key_release, key_extended, frame_err;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  err_seen = 0;
    int  err_exp = 0;
    logic kv_prev = 1'b0;

    ps2_scancode_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(2000)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .keycode     (keycode),
        .key_valid   (key_valid),
        .key_release (key_release),
        .key_extended(key_extended),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Monitor: every key_valid must match the head of the expected queue.
    always @(negedge clk) begin
        ev_t e;
        if (rst && key_valid) begin
            checks++;
            if (kv_prev) begin
                errors++;
                $display("FAIL key_valid_width: high on consecutive cycles, required single-cycle");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_key_valid: got code=%h rel=%b ext=%b, required none",
                         keycode, key_release, key_extended);
            end else begin
                e = exp_q.pop_front();
                if ({keycode, key_release, key_extended} !== e) begin
                    errors++;
                    $display("FAIL key_event: got code=%h rel=%b ext=%b, required code=%h rel=%b ext=%b",
                             keycode, key_release, key_extended, e.code, e.rel, e.ext);
                end
            end
        end
        kv_prev = key_valid;
        if (frame_err) err_seen++;
    end

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic good_par);
        logic p;
        p = good_par ? ~(^b) : (^b);
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bits first..last of a frame; data changes mid-high, ends mid-high.
    task automatic send_range(input logic [10:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            ps2_data = f[i];
            wait_cycles(HALF / 2);
            ps2_clk = 1'b0;
            wait_cycles(HALF);
            ps2_clk = 1'b1;
            wait_cycles(HALF / 2);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_range(make_frame(b, 1'b1), 0, 10);
        wait_cycles(300);
    endtask

    task automatic expect_ev(input logic [7:0] c, input logic r, input logic x);
        ev_t e;
        e.code = c;
        e.rel  = r;
        e.ext  = x;
        exp_q.push_back(e);
    endtask

    task automatic check_drain(input string name);
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected events still pending, required 0", name,
                     exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (err_seen != err_exp) begin
            errors++;
            $display("FAIL %s_frame_err: got %0d pulses, required %0d", name, err_seen, err_exp);
            err_exp = err_seen;
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({keycode, key_valid, key_release, key_extended, frame_err} !== 12'h000) begin
            errors++;
            $display("FAIL %s: got code=%h kv=%b rel=%b ext=%b fe=%b, required all 0", name,
                     keycode, key_valid, key_release, key_extended, frame_err);
        end
    endtask

    initial begin
        wait_cycles(5);
        check_outputs_zero("reset_state");
        rst = 1'b1;
        wait_cycles(50);

        expect_ev(8'h75, 1'b0, 1'b0);
        send_byte(8'h75);
        check_drain("t1_make");

        expect_ev(8'h75, 1'b1, 1'b0);
        send_byte(8'hF0);
        send_byte(8'h75);
        expect_ev(8'h72, 1'b0, 1'b0);
        send_byte(8'h72);
        check_drain("t2_break");

        expect_ev(8'h6B, 1'b1, 1'b1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h6B);
        expect_ev(8'h5A, 1'b0, 1'b0);
        send_byte(8'h5A);
        check_drain("t3_ext_break");

        err_exp++;
        send_range(make_frame(8'h5A, 1'b0), 0, 10);
        wait_cycles(300);
        check_drain("t4_parity");
        checks++;
        if (keycode !== 8'h5A) begin
            errors++;
            $display("FAIL t4_keycode_hold: got %h, required 5a", keycode);
        end
        expect_ev(8'h76, 1'b0, 1'b0);
        send_byte(8'h76);
        check_drain("t4_recover");

        send_range(make_frame(8'h11, 1'b1), 0, 4);
        wait_cycles(2500);
        err_exp++;
        check_drain("t5_timeout");
        expect_ev(8'h6B, 1'b0, 1'b0);
        send_byte(8'h6B);
        check_drain("t5_recover");

        ps2_clk = 1'b0;
        wait_cycles(2);
        ps2_clk = 1'b1;
        wait_cycles(500);
        check_drain("t6_glitch");

        // All-ones byte: the bits left after the reset never look like a start bit.
        send_range(make_frame(8'hFF, 1'b1), 0, 3);
        rst = 1'b0;
        wait_cycles(1);
        rst = 1'b1;
        check_outputs_zero("t6_reset_mid_frame");
        send_range(make_frame(8'hFF, 1'b1), 4, 10);
        wait_cycles(300);
        check_drain("t6_tail");
        expect_ev(8'h75, 1'b0, 1'b0);
        send_byte(8'h75);
        check_drain("t6_recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
Upstream PS/2 front end for the keyboard decoder. It synchronises and filters the raw ps2_clk/ps2_data lines, deframes 11-bit PS/2 frames, and checks start, parity and stop bits. It strips the E0 (extended) and F0 (break) prefixes and presents one decoded scan code per key event. Its keycode output feeds the keyboard-to-key mapping stage directly; key_valid, key_release and key_extended let downstream logic tell press from release.

Parameters:
FILTER_LEN, 4, consecutive equal synchronised samples required before the filtered ps2_clk level changes (2..15)
TIMEOUT_CYCLES, 100000, clk cycles without a ps2_clk falling edge after which a partial frame is abandoned (1 ms at 100 MHz)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
ps2_clk  input  1  raw PS/2 clock from the pin, asynchronous
ps2_data  input  1  raw PS/2 data from the pin, asynchronous
keycode  output  8  last decoded scan code (prefixes removed), held between events
key_valid  output  1  one-cycle strobe: keycode/key_release/key_extended updated this cycle
key_release  output  1  1 = event was a break (F0-prefixed)
key_extended  output  1  1 = event was E0-prefixed
frame_err  output  1  one-cycle strobe: bad start/parity/stop bit, or timeout

Behaviour:
- Reset: rst sampled low on a clk edge causes:
  - keycode=0, key_valid=0, key_release=0, key_extended=0, frame_err=0
  - FSM=IDLE, bit counter=0, prefix flags cleared, timeout counter=0
  - synchronisers and filtered clock preset to 1
  - a partial frame is discarded with no strobe.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - Filtered clock changes level only after FILTER_LEN consecutive identical synchronised samples.
  - fall_stb is a one-cycle internal strobe on a 1->0 transition of the filtered clock.
  - Data is sampled (synchronised value) in the fall_stb cycle.
- Frame FSM, advances only on fall_stb:
  - IDLE: data=0 -> DATA, bit_cnt=0. data=1 -> stay in IDLE, no error.
  - DATA: shift right, new bit into bit 7 (LSB first); after the 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: frame good if stop=1 and XOR of 8 data bits plus parity = 1 (odd parity).
    - Good: byte_rdy strobe.
    - Bad: frame_err strobe and prefix flags cleared.
    - Either way -> IDLE.
- Timeout:
  - Counter clears on every fall_stb and while in IDLE.
  - In DATA/PARITY/STOP, reaching TIMEOUT_CYCLES-1 forces IDLE, pulses frame_err and clears prefix flags.
- Prefix decoder, on byte_rdy:
  - 0xE0: ext_flag<=1, no output.
  - 0xF0: brk_flag<=1, no output.
  - Any other byte (including 0xAA, 0xFA, 0xE1): keycode<=byte, key_release<=brk_flag, key_extended<=ext_flag, key_valid<=1, then both flags cleared.
  - Sequence E0 F0 xx reports release=1, extended=1.
  - Repeated prefixes are idempotent.
- Latency: key_valid and frame_err (for bit errors) assert exactly 2 clk cycles after the fall_stb of the stop bit.
- Outputs:
  - key_valid and frame_err are single-cycle.
  - keycode, key_release and key_extended hold until the next key_valid; no change on errors.
- A fall_stb cannot coincide with byte_rdy processing, so no simultaneous-event arbitration is needed.

Test Plan:
Bench setup: FILTER_LEN=4, TIMEOUT_CYCLES=2000, PS/2 half-period = 200 clk cycles, data changes mid-high phase.
1. Frame 0x75 (parity 0, stop 1) -> one key_valid pulse, keycode=0x75, key_release=0, key_extended=0, frame_err never high.
2. Bytes F0, 75 -> exactly one key_valid, keycode=0x75, key_release=1, key_extended=0. A following 0x72 gives release=0.
3. Bytes E0, F0, 6B, then 5A -> first key_valid: keycode=0x6B, rel=1, ext=1. Second: keycode=0x5A, rel=0, ext=0. Total 2 key_valid pulses.
4. 0x5A sent with parity bit 0 (correct is 1) -> one frame_err pulse, no key_valid, keycode keeps its prior value. A next clean 0x76 -> keycode=0x76.
5. Frame stopped after start plus 4 data bits, idle for 2500 cycles -> frame_err pulse once. A subsequent clean 0x6B -> keycode=0x6B, no further errors.
6. 2-cycle low glitch on ps2_clk in IDLE -> no state change, no strobes. Separately, rst driven low for 1 cycle mid-frame after 3 data bits -> all outputs 0. The remaining bits of the interrupted frame produce no key_valid, and the next full 0x75 frame decodes correctly.
